// File: rtl/clock_time_setter.sv
// clock_time_setter: presses the clock's keys to walk its displayed time to a target hh:mm:ss.
// Define CLOCK_SETTER_VERIFY_EN to re-read the displays after setting and flag a mismatch.
module clock_time_setter #(
   parameter int unsigned PRESS_CYC  = 2,
   parameter int unsigned GAP_CYC    = 2,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic       clk,
   input  logic       key0_rst,
   input  logic       start,
   input  logic [4:0] tgt_hour,
   input  logic [5:0] tgt_min,
   input  logic [5:0] tgt_sec,
   input  logic [6:0] hex2_sec,
   input  logic [6:0] hex3_sec,
   input  logic [6:0] hex4_min,
   input  logic [6:0] hex5_min,
   input  logic [6:0] hex6_hour,
   input  logic [6:0] hex7_hour,
   output logic       key1_mode,
   output logic       key2_next,
   output logic       key3_incr,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam int unsigned PG = PRESS_CYC + GAP_CYC;
   localparam int unsigned CW = $clog2((PG > SETTLE_CYC ? PG : SETTLE_CYC) + 1);
   typedef enum logic [3:0] {IDLE, MODE_IN, SETTLE, CAPTURE, FIELD, NEXT, VWAIT, VERIFY, MODE_OUT, FINISH} state_t;
`ifdef CLOCK_SETTER_VERIFY_EN
   localparam state_t AFTER = VWAIT;
`else
   localparam state_t AFTER = MODE_OUT;
`endif
   state_t        state, state_nx;
   logic [CW-1:0] pc;
   logic [5:0]    rem, n_min_q, n_hour_q, n_sec, n_min, n_hour;
   logic [1:0]    fld;
   logic [4:0]    t_hour;
   logic [5:0]    t_min, t_sec;
   logic          fail, armed, err_bad;
   logic [4:0]    d2, d3, d4, d5, d6, d7;
   logic [6:0]    cur_sec, cur_min, cur_hour, d_sec, d_min, d_hour;
   logic          cur_ok, tgt_ok, go, low, incr_act, counting, cnt_last;

   // {valid, digit} from an active-low gfedcba pattern
   function automatic logic [4:0] dec(input logic [6:0] s);
      case (s)
         7'h40:   return 5'h10;
         7'h79:   return 5'h11;
         7'h24:   return 5'h12;
         7'h30:   return 5'h13;
         7'h19:   return 5'h14;
         7'h12:   return 5'h15;
         7'h02:   return 5'h16;
         7'h78:   return 5'h17;
         7'h00:   return 5'h18;
         7'h10:   return 5'h19;
         default: return 5'h00;
      endcase
   endfunction

   function automatic logic [6:0] num(input logic [4:0] t, input logic [4:0] u);
      return {3'd0, t[3:0]} * 7'd10 + {3'd0, u[3:0]};
   endfunction

   assign d2 = dec(hex2_sec);
   assign d3 = dec(hex3_sec);
   assign d4 = dec(hex4_min);
   assign d5 = dec(hex5_min);
   assign d6 = dec(hex6_hour);
   assign d7 = dec(hex7_hour);
   assign cur_sec  = num(d3, d2);
   assign cur_min  = num(d5, d4);
   assign cur_hour = num(d7, d6);
   assign cur_ok = d2[4] & d3[4] & d4[4] & d5[4] & d6[4] & d7[4] &
                   (d3[3:0] <= 4'd5) & (d5[3:0] <= 4'd5) & (cur_hour <= 7'd23);
   // forward distance to the target, modulo the field's range
   assign d_sec  = {1'b0, t_sec} + 7'd60 - cur_sec;
   assign d_min  = {1'b0, t_min} + 7'd60 - cur_min;
   assign d_hour = {2'b0, t_hour} + 7'd24 - cur_hour;
   assign n_sec  = 6'(d_sec >= 7'd60 ? d_sec - 7'd60 : d_sec);
   assign n_min  = 6'(d_min >= 7'd60 ? d_min - 7'd60 : d_min);
   assign n_hour = 6'(d_hour >= 7'd24 ? d_hour - 7'd24 : d_hour);
   assign tgt_ok = (tgt_hour <= 5'd23) & (tgt_min <= 6'd59) & (tgt_sec <= 6'd59);
   assign go = (state == IDLE) & start & armed;
   assign low = pc < CW'(PRESS_CYC);
   assign incr_act = (state == FIELD) & (rem != 6'd0);
   assign counting = (state inside {MODE_IN, SETTLE, NEXT, VWAIT, MODE_OUT}) | incr_act;
   assign cnt_last = pc == ((state == SETTLE || state == VWAIT) ? CW'(SETTLE_CYC - 1) : CW'(PG - 1));

   always_ff @(posedge clk or negedge key0_rst)
      if (!key0_rst) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      key1_mode = !((state == MODE_IN || state == MODE_OUT) && low);
      key2_next = !(state == NEXT && low);
      key3_incr = !(incr_act && low);
      busy = state != IDLE;
      done = (state == FINISH) & !fail;
      err = err_bad | ((state == FINISH) & fail);
      case (state)
         IDLE:     state_nx = go && tgt_ok ? MODE_IN : IDLE;
         MODE_IN:  state_nx = cnt_last ? SETTLE : MODE_IN;
         SETTLE:   state_nx = cnt_last ? CAPTURE : SETTLE;
         CAPTURE:  state_nx = cur_ok ? FIELD : MODE_OUT;
         FIELD:    state_nx = incr_act ? FIELD : (fld == 2'd2 ? AFTER : NEXT);
         NEXT:     state_nx = cnt_last ? FIELD : NEXT;
         VWAIT:    state_nx = cnt_last ? VERIFY : VWAIT;
         VERIFY:   state_nx = MODE_OUT;
         MODE_OUT: state_nx = cnt_last ? FINISH : MODE_OUT;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge key0_rst) begin
      if (!key0_rst) begin
         pc <= '0;
         rem <= '0;
         n_min_q <= '0;
         n_hour_q <= '0;
         fld <= '0;
         t_hour <= '0;
         t_min <= '0;
         t_sec <= '0;
         fail <= 1'b0;
         armed <= 1'b0;
         err_bad <= 1'b0;
      end else begin
         armed <= 1'b1;
         err_bad <= go & !tgt_ok;
         pc <= counting && !cnt_last ? pc + 1'b1 : '0;
         if (go && tgt_ok) begin
            t_hour <= tgt_hour;
            t_min <= tgt_min;
            t_sec <= tgt_sec;
            fail <= 1'b0;
         end
         if (state == CAPTURE) begin
            fail <= !cur_ok;
            rem <= n_sec;
            n_min_q <= n_min;
            n_hour_q <= n_hour;
            fld <= 2'd0;
         end
         if (incr_act && cnt_last) rem <= rem - 1'b1;
         if (state == NEXT && cnt_last) begin
            fld <= fld + 1'b1;
            rem <= fld == 2'd0 ? n_min_q : n_hour_q;
         end
         if (state == VERIFY)
            fail <= fail | !cur_ok | (cur_sec != {1'b0, t_sec}) | (cur_min != {1'b0, t_min}) |
                    (cur_hour != {2'b0, t_hour});
      end
   end
endmodule

// File: tb/tb_clock_time_setter.sv
// tb_clock_time_setter: drives clock_time_setter against a behavioural key/display clock model.
// Build with CLOCK_SETTER_VERIFY_EN to add the dropped-increment readback case.
module tb_clock_time_setter;
   localparam int GAP = 2;
   logic       clk = 1'b0, key0_rst = 1'b0, start = 1'b0;
   logic [4:0] tgt_hour = '0;
   logic [5:0] tgt_min = '0, tgt_sec = '0;
   logic [6:0] hex2_sec, hex3_sec, hex4_min, hex5_min, hex6_hour, hex7_hour;
   logic       key1_mode, key2_next, key3_incr, busy, done, err;
   int         checks = 0, errors = 0, gap = 0;
   int         hh = 0, mm = 0, ss = 0, fld_m = 0;
   int         n_mode = 0, n_next = 0, n_done = 0, n_err = 0, n_busy = 0, viol = 0, hi_run = 0;
   int         n_inc [3];
   int         ld_h = 0, ld_m = 0, ld_s = 0;
   logic       set_m = 1'b0, clr = 1'b0, ld = 1'b0, bad = 1'b0, drop = 1'b0, drop_used = 1'b0;
   logic [2:0] kp = 3'b111;

   clock_time_setter dut (
      .clk(clk), .key0_rst(key0_rst), .start(start),
      .tgt_hour(tgt_hour), .tgt_min(tgt_min), .tgt_sec(tgt_sec),
      .hex2_sec(hex2_sec), .hex3_sec(hex3_sec), .hex4_min(hex4_min),
      .hex5_min(hex5_min), .hex6_hour(hex6_hour), .hex7_hour(hex7_hour),
      .key1_mode(key1_mode), .key2_next(key2_next), .key3_incr(key3_incr),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         default: return 7'h10;
      endcase
   endfunction

   assign hex2_sec  = seg(ss % 10);
   assign hex3_sec  = seg(ss / 10);
   assign hex4_min  = bad ? 7'h7F : seg(mm % 10);
   assign hex5_min  = seg(mm / 10);
   assign hex6_hour = seg(hh % 10);
   assign hex7_hour = seg(hh / 10);

   // clock model: reacts to key falling edges, also tallies presses and pulses
   always @(posedge clk or negedge key0_rst) begin
      if (!key0_rst) begin
         set_m <= 1'b0;
         fld_m <= 0;
         kp <= 3'b111;
      end else begin
         kp <= {key3_incr, key2_next, key1_mode};
         if (ld) begin
            hh <= ld_h;
            mm <= ld_m;
            ss <= ld_s;
         end
         if (clr) begin
            n_mode <= 0; n_next <= 0; n_done <= 0; n_err <= 0; n_busy <= 0; viol <= 0; hi_run <= 0;
            n_inc[0] <= 0; n_inc[1] <= 0; n_inc[2] <= 0;
            drop_used <= 1'b0;
         end else begin
            n_done <= n_done + int'(done);
            n_err <= n_err + int'(err);
            n_busy <= n_busy + int'(busy);
            hi_run <= (key1_mode && key2_next && key3_incr) ? hi_run + 1 : 0;
            if (int'(!key1_mode) + int'(!key2_next) + int'(!key3_incr) > 1) viol <= viol + 1;
            if (kp[0] && !key1_mode) begin
               n_mode <= n_mode + 1;
               set_m <= !set_m;
               fld_m <= 0;
            end
            if (kp[1] && !key2_next) begin
               n_next <= n_next + 1;
               if (set_m) fld_m <= fld_m == 2 ? 0 : fld_m + 1;
            end
            if (kp[2] && !key3_incr) begin
               n_inc[fld_m] <= n_inc[fld_m] + 1;
               if (set_m && drop && !drop_used) drop_used <= 1'b1;
               else if (set_m)
                  case (fld_m)
                     0: ss <= (ss + 1) % 60;
                     1: mm <= (mm + 1) % 60;
                     default: hh <= (hh + 1) % 24;
                  endcase
            end
         end
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic prep(input int h, input int m, input int s);
      ld_h = h; ld_m = m; ld_s = s;
      ld = 1'b1; clr = 1'b1;
      @(negedge clk);
      ld = 1'b0; clr = 1'b0;
   endtask

   task automatic kick(input int h, input int m, input int s);
      tgt_hour = 5'(h); tgt_min = 6'(m); tgt_sec = 6'(s);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run(input string tag, input int h, input int m, input int s);
      kick(h, m, s);
      for (int i = 0; i < 3000 && !(done || err); i++) @(negedge clk);
      gap = hi_run;
      chk({tag, " finished"}, int'(done || err), 1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset keys", int'({key3_incr, key2_next, key1_mode}), 7);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset err", int'(err), 0);
      key0_rst = 1'b1;
      @(negedge clk);

      prep(0, 0, 0);
      run("t1", 1, 2, 3);
      chk("t1 time", hh * 10000 + mm * 100 + ss, 10203);
      chk("t1 mode presses", n_mode, 2);
      chk("t1 next presses", n_next, 2);
      chk("t1 sec incr", n_inc[0], 3);
      chk("t1 min incr", n_inc[1], 2);
      chk("t1 hour incr", n_inc[2], 1);
      chk("t1 done pulses", n_done, 1);
      chk("t1 err pulses", n_err, 0);
      chk("t1 gap before done", gap, GAP);
      chk("t1 run mode", int'(set_m), 0);
      chk("t1 one key at a time", viol, 0);
      chk("t1 busy after", int'(busy), 0);

      prep(23, 59, 58);
      run("t2", 0, 0, 0);
      chk("t2 time", hh * 10000 + mm * 100 + ss, 0);
      chk("t2 sec incr", n_inc[0], 2);
      chk("t2 min incr", n_inc[1], 1);
      chk("t2 hour incr", n_inc[2], 1);
      chk("t2 done pulses", n_done, 1);

      prep(12, 34, 56);
      run("t3", 12, 34, 56);
      chk("t3 incr total", n_inc[0] + n_inc[1] + n_inc[2], 0);
      chk("t3 mode presses", n_mode, 2);
      chk("t3 next presses", n_next, 2);
      chk("t3 done pulses", n_done, 1);
      chk("t3 time", hh * 10000 + mm * 100 + ss, 123456);

      prep(5, 5, 5);
      kick(24, 0, 0);
      chk("bad hour err", int'(err), 1);
      chk("bad hour busy", int'(busy), 0);
      @(negedge clk);
      chk("bad hour err width", int'(err), 0);
      kick(0, 0, 60);
      chk("bad sec err", int'(err), 1);
      repeat (4) @(negedge clk);
      chk("bad presses", n_mode + n_next + n_inc[0] + n_inc[1] + n_inc[2], 0);
      chk("bad busy seen", n_busy, 0);
      chk("bad err pulses", n_err, 2);

      prep(0, 0, 0);
      bad = 1'b1;
      run("t5", 1, 2, 3);
      bad = 1'b0;
      chk("t5 mode presses", n_mode, 2);
      chk("t5 next presses", n_next, 0);
      chk("t5 incr total", n_inc[0] + n_inc[1] + n_inc[2], 0);
      chk("t5 err pulses", n_err, 1);
      chk("t5 done pulses", n_done, 0);

`ifdef CLOCK_SETTER_VERIFY_EN
      prep(0, 0, 0);
      drop = 1'b1;
      run("t6", 1, 2, 3);
      drop = 1'b0;
      chk("t6 err pulses", n_err, 1);
      chk("t6 done pulses", n_done, 0);
`endif

      prep(0, 0, 0);
      kick(0, 0, 5);
      for (int i = 0; i < 200 && key3_incr; i++) @(negedge clk);
      chk("t7 incr held", int'(key3_incr), 0);
      key0_rst = 1'b0;
      #1;
      chk("t7 keys on reset", int'({key3_incr, key2_next, key1_mode}), 7);
      chk("t7 busy on reset", int'(busy), 0);
      @(negedge clk);
      key0_rst = 1'b1;
      tgt_hour = 5'd0; tgt_min = 6'd0; tgt_sec = 6'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t7 start at release", int'(busy), 0);
      prep(0, 0, 1);
      run("t7", 0, 0, 5);
      chk("t7 time", hh * 10000 + mm * 100 + ss, 5);
      chk("t7 sec incr", n_inc[0], 4);
      chk("t7 done pulses", n_done, 1);
      chk("t7 one key at a time", viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
